irq_priority_encoder: RTL and testbench
=======================================

// Module: irq_priority_encoder
// PURPOSE
//   16-to-4 registered priority encoder with request/acknowledge handshake. It is the
//   encode direction of the 4-to-16 timing/select decoder. It collects 16 request
//   lines into sticky pending bits and applies a mask. It presents the index of the
//   highest-priority unmasked pending source to the control unit as code + irq, and
//   clears that source when the control unit acknowledges it.
// PARAMETERS
//   N      16  number of request sources (fixed; code width is 4 bits)
//   IDX_W  4   width of code output, = log2(N)
// PORTS
//   clk      in   1   system clock, all state updates on rising edge
//   rst_n    in   1   asynchronous reset, active-low
//   req      in   16  request lines, level-sampled each rising edge
//   mask_we  in   1   load mask from mask_in this edge
//   mask_in  in   16  new mask value (1 = source masked)
//   ien      in   1   global enable; 0 = no irq is raised
//   ack      in   1   control unit accepts the current code (meaningful only when irq=1)
//   irq      out  1   request to control unit, registered
//   code     out  4   index of the granted source, registered, stable while irq=1
//   pending  out  16  sticky pending register (status/debug)
// BEHAVIOUR
//   Reset (async, rst_n=0): pending=0, mask=0 (all sources enabled), irq=0, code=0,
//     state=IDLE. Applies immediately. Any request in progress is abandoned.
//   pending[i]: set at an edge where req[i]=1. Cleared only by ack for i == code.
//     Set wins over clear in the same cycle, so no request is lost.
//   mask: loaded from mask_in on mask_we. A mask change never alters pending.
//   cand = pending & ~mask. Priority is fixed: lowest index wins (bit 0 highest).
//   FSM states IDLE, REQ, CLR:
//     IDLE: irq=0. If ien=1 and cand!=0: code <= index of lowest set bit of cand,
//       irq <= 1, go to REQ. Otherwise stay in IDLE; code holds its last value.
//     REQ: irq=1 and code frozen. No preemption: newly arriving higher-priority
//       sources wait. Mask changes do not withdraw the request.
//       ack=1: pending[code] cleared (unless req[code]=1 that edge), irq<=0, go to CLR.
//       ack=0 and ien=0: irq<=0, go to IDLE, pending untouched (request withdrawn).
//       ack and ien=0 together: the ack wins and the source is cleared.
//     CLR: irq=0 for exactly one cycle (guaranteed gap), then go to IDLE.
//   ack outside REQ: ignored. Does not touch pending.
//   Latency: req[i] high before edge k, with no competition:
//     pending[i]=1 after edge k; irq=1 and code=i after edge k+1.
//   Back-to-back sources: after the ack edge, the next irq rises 2 edges later
//     (CLR, then IDLE->REQ).
//   All outputs are driven directly from flops. No combinational path runs from
//     inputs to outputs.
// TESTING
//   1 Reset: rst_n=0 mid-operation with irq=1 -> irq=0, code=0, pending=0 immediately,
//     without waiting for a clock edge. After release, no irq until a new req arrives.
//   2 Single source: ien=1, mask=0, req=0x0020 for 1 cycle -> pending=0x0020 at k,
//     irq=1 code=5 at k+1. ack=1 for 1 cycle -> pending=0, irq=0, one CLR cycle,
//     then back to IDLE.
//   3 Priority: req=0x8001 in one cycle -> code=0 first. ack -> one CLR cycle ->
//     code=15, irq=1. ack -> pending=0.
//   4 Masking: mask_we with 0x0001, req=0x0003 -> code=1 only. Clear the mask and
//     then ack -> code=0 next.
//   5 No preemption: in REQ with code=9, req=0x0004 -> code stays 9 and irq=1 until ack.
//     Then code=2 two edges after the ack.
//   6 Corners: req[9]=1 on the same edge as ack for code 9 -> pending[9] stays 1 and
//     irq reasserts with code=9 after CLR. ien dropped in REQ -> irq=0 and pending is
//     kept. ack while irq=0 -> no effect.

Source files
------------

// File: rtl/irq_priority_encoder.sv
// Registered 16-to-4 interrupt priority encoder: sticky pending bits, a source mask,
// and an irq/ack handshake that holds the granted code stable until it is acknowledged.
module irq_priority_encoder #(
    parameter int unsigned N     = 16,
    parameter int unsigned IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             mask_we,
    input  logic [N-1:0]     mask_in,
    input  logic             ien,
    input  logic             ack,
    output logic             irq,
    output logic [IDX_W-1:0] code,
    output logic [N-1:0]     pending
);

    typedef enum logic [1:0] {StIdle, StReq, StClr} state_e;

    state_e           state_q, state_d;
    logic [N-1:0]     pending_q, pending_d;
    logic [N-1:0]     mask_q, mask_d;
    logic             irq_q, irq_d;
    logic [IDX_W-1:0] code_q, code_d;

    logic [N-1:0]     cand;
    logic [IDX_W-1:0] lsb_idx;
    logic [N-1:0]     code_onehot;

    assign cand        = pending_q & ~mask_q;
    assign code_onehot = N'(1) << code_q;
    assign mask_d      = mask_we ? mask_in : mask_q;

    // Scan downwards so the lowest set index is the last (winning) assignment.
    always_comb begin
        lsb_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (cand[i]) lsb_idx = IDX_W'(i);
        end
    end

    always_comb begin
        state_d   = state_q;
        irq_d     = irq_q;
        code_d    = code_q;
        pending_d = pending_q | req;
        unique case (state_q)
            StIdle: begin
                irq_d = 1'b0;
                if (ien && (cand != '0)) begin
                    code_d  = lsb_idx;
                    irq_d   = 1'b1;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (ack) begin
                    // A fresh request on the same edge re-sets the bit, so nothing is lost.
                    pending_d = (pending_q & ~code_onehot) | req;
                    irq_d     = 1'b0;
                    state_d   = StClr;
                end else if (!ien) begin
                    irq_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            StClr: begin
                irq_d   = 1'b0;
                state_d = StIdle;
            end
            default: begin
                irq_d   = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            pending_q <= '0;
            mask_q    <= '0;
            irq_q     <= 1'b0;
            code_q    <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            irq_q     <= irq_d;
            code_q    <= code_d;
        end
    end

    assign irq     = irq_q;
    assign code    = code_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_irq_priority_encoder.sv
// Directed testbench for irq_priority_encoder; compares {irq, code, pending} against
// hand-computed values after each clock edge.
module tb_irq_priority_encoder;

    logic        clk;
    logic        rst_n;
    logic [15:0] req;
    logic        mask_we;
    logic [15:0] mask_in;
    logic        ien;
    logic        ack;
    logic        irq;
    logic [3:0]  code;
    logic [15:0] pending;

    int checks;
    int errors;

    irq_priority_encoder #(.N(16), .IDX_W(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .mask_we (mask_we),
        .mask_in (mask_in),
        .ien     (ien),
        .ack     (ack),
        .irq     (irq),
        .code    (code),
        .pending (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if ({irq, code, pending} !== 21'h0) begin
            $display("FAIL reset_initial: got irq=%b code=%0d pending=%h, want 0/0/0000",
                     irq, code, pending);
            errors++;
        end
        tick();
        rst_n = 1'b1;
        req = 16'h0010;
        tick();
        req = 16'h0000;
        tick();
        checks++;
        if ({irq, code, pending} !== {1'b1, 4'd4, 16'h0010}) begin
            $display("FAIL reset_pre_irq: got irq=%b code=%0d pending=%h, want 1/4/0010",
                     irq, code, pending);
            errors++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({irq, code, pending} !== 21'h0) begin
            $display("FAIL reset_async: got irq=%b code=%0d pending=%h, want 0/0/0000",
                     irq, code, pending);
            errors++;
        end
        #3;
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if ({irq, code, pending} !== 21'h0) begin
            $display("FAIL reset_quiet: got irq=%b code=%0d pending=%h, want 0/0/0000",
                     irq, code, pending);
            errors++;
        end
    endtask

    task automatic test_single();
        req = 16'h0020;
        tick();
        req = 16'h0000;
        checks++;
        if ({irq, pending} !== {1'b0, 16'h0020}) begin
            $display("FAIL single_pending: got irq=%b pending=%h, want 0/0020", irq, pending);
            errors++;
        end
        tick();
        checks++;
        if ({irq, code, pending} !== {1'b1, 4'd5, 16'h0020}) begin
            $display("FAIL single_irq: got irq=%b code=%0d pending=%h, want 1/5/0020",
                     irq, code, pending);
            errors++;
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        checks++;
        if ({irq, code, pending} !== {1'b0, 4'd5, 16'h0000}) begin
            $display("FAIL single_ack: got irq=%b code=%0d pending=%h, want 0/5/0000",
                     irq, code, pending);
            errors++;
        end
        tick();
        tick();
        checks++;
        if ({irq, pending} !== {1'b0, 16'h0000}) begin
            $display("FAIL single_idle: got irq=%b pending=%h, want 0/0000", irq, pending);
            errors++;
        end
    endtask

    task automatic test_priority();
        req = 16'h8001;
        tick();
        req = 16'h0000;
        tick();
        checks++;
        if ({irq, code, pending} !== {1'b1, 4'd0, 16'h8001}) begin
            $display("FAIL prio_first: got irq=%b code=%0d pending=%h, want 1/0/8001",
                     irq, code, pending);
            errors++;
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        checks++;
        if ({irq, pending} !== {1'b0, 16'h8000}) begin
            $display("FAIL prio_clr: got irq=%b pending=%h, want 0/8000", irq, pending);
            errors++;
        end
        tick();
        checks++;
        if (irq !== 1'b0) begin
            $display("FAIL prio_gap: got irq=%b, want 0", irq);
            errors++;
        end
        tick();
        checks++;
        if ({irq, code} !== {1'b1, 4'd15}) begin
            $display("FAIL prio_second: got irq=%b code=%0d, want 1/15", irq, code);
            errors++;
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        checks++;
        if ({irq, pending} !== {1'b0, 16'h0000}) begin
            $display("FAIL prio_done: got irq=%b pending=%h, want 0/0000", irq, pending);
            errors++;
        end
        tick();
    endtask

    task automatic test_mask();
        mask_we = 1'b1;
        mask_in = 16'h0001;
        req     = 16'h0003;
        tick();
        mask_we = 1'b0;
        req     = 16'h0000;
        tick();
        checks++;
        if ({irq, code, pending} !== {1'b1, 4'd1, 16'h0003}) begin
            $display("FAIL mask_grant: got irq=%b code=%0d pending=%h, want 1/1/0003",
                     irq, code, pending);
            errors++;
        end
        mask_we = 1'b1;
        mask_in = 16'h0000;
        tick();
        mask_we = 1'b0;
        checks++;
        if ({irq, code, pending} !== {1'b1, 4'd1, 16'h0003}) begin
            $display("FAIL mask_hold: got irq=%b code=%0d pending=%h, want 1/1/0003",
                     irq, code, pending);
            errors++;
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
        tick();
        checks++;
        if ({irq, code, pending} !== {1'b1, 4'd0, 16'h0001}) begin
            $display("FAIL mask_next: got irq=%b code=%0d pending=%h, want 1/0/0001",
                     irq, code, pending);
            errors++;
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
    endtask

    task automatic test_no_preempt();
        req = 16'h0200;
        tick();
        req = 16'h0000;
        tick();
        req = 16'h0004;
        tick();
        req = 16'h0000;
        tick();
        checks++;
        if ({irq, code, pending} !== {1'b1, 4'd9, 16'h0204}) begin
            $display("FAIL nopre_hold: got irq=%b code=%0d pending=%h, want 1/9/0204",
                     irq, code, pending);
            errors++;
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
        checks++;
        if (irq !== 1'b0) begin
            $display("FAIL nopre_gap: got irq=%b, want 0", irq);
            errors++;
        end
        tick();
        checks++;
        if ({irq, code, pending} !== {1'b1, 4'd2, 16'h0004}) begin
            $display("FAIL nopre_next: got irq=%b code=%0d pending=%h, want 1/2/0004",
                     irq, code, pending);
            errors++;
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
    endtask

    task automatic test_corners();
        req = 16'h0200;
        tick();
        req = 16'h0000;
        tick();
        ack = 1'b1;
        req = 16'h0200;
        tick();
        ack = 1'b0;
        req = 16'h0000;
        checks++;
        if ({irq, pending} !== {1'b0, 16'h0200}) begin
            $display("FAIL corner_setwins: got irq=%b pending=%h, want 0/0200", irq, pending);
            errors++;
        end
        tick();
        tick();
        checks++;
        if ({irq, code} !== {1'b1, 4'd9}) begin
            $display("FAIL corner_reassert: got irq=%b code=%0d, want 1/9", irq, code);
            errors++;
        end
        ien = 1'b0;
        tick();
        checks++;
        if ({irq, pending} !== {1'b0, 16'h0200}) begin
            $display("FAIL corner_withdraw: got irq=%b pending=%h, want 0/0200", irq, pending);
            errors++;
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        checks++;
        if ({irq, pending} !== {1'b0, 16'h0200}) begin
            $display("FAIL corner_stray_ack: got irq=%b pending=%h, want 0/0200", irq, pending);
            errors++;
        end
        ien = 1'b1;
        tick();
        checks++;
        if ({irq, code} !== {1'b1, 4'd9}) begin
            $display("FAIL corner_reenable: got irq=%b code=%0d, want 1/9", irq, code);
            errors++;
        end
        ack = 1'b1;
        ien = 1'b0;
        tick();
        ack = 1'b0;
        ien = 1'b1;
        checks++;
        if ({irq, pending} !== {1'b0, 16'h0000}) begin
            $display("FAIL corner_ack_wins: got irq=%b pending=%h, want 0/0000", irq, pending);
            errors++;
        end
        tick();
        tick();
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b1;
        req     = 16'h0000;
        mask_we = 1'b0;
        mask_in = 16'h0000;
        ien     = 1'b1;
        ack     = 1'b0;
        test_reset();
        test_single();
        test_priority();
        test_mask();
        test_no_preempt();
        test_corners();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
